// File: rtl/cpu_pkg.sv
// Shared veriRISC constants: opcode and phase encodings plus the ALU-opcode helper.
// The controller, its phase counter and the datapath decode all import this.
package cpu_pkg;

    localparam int WIDTH = 3;

    localparam logic [WIDTH-1:0] HLT = 3'd0;
    localparam logic [WIDTH-1:0] SKZ = 3'd1;
    localparam logic [WIDTH-1:0] ADD = 3'd2;
    localparam logic [WIDTH-1:0] AND = 3'd3;
    localparam logic [WIDTH-1:0] XOR = 3'd4;
    localparam logic [WIDTH-1:0] LDA = 3'd5;
    localparam logic [WIDTH-1:0] STO = 3'd6;
    localparam logic [WIDTH-1:0] JMP = 3'd7;

    localparam logic [WIDTH-1:0] INST_ADDR  = 3'd0;
    localparam logic [WIDTH-1:0] INST_FETCH = 3'd1;
    localparam logic [WIDTH-1:0] INST_LOAD  = 3'd2;
    localparam logic [WIDTH-1:0] IDLE       = 3'd3;
    localparam logic [WIDTH-1:0] OP_ADDR    = 3'd4;
    localparam logic [WIDTH-1:0] OP_FETCH   = 3'd5;
    localparam logic [WIDTH-1:0] ALU_OP     = 3'd6;
    localparam logic [WIDTH-1:0] STORE      = 3'd7;

    // Opcodes whose result comes back through the ALU into the accumulator.
    function automatic logic is_aluop(input logic [WIDTH-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller-to-datapath bundle: instruction inputs, strobes and debug phase.
// master = the sequencer, slave = the datapath/instruction register side.
interface cpu_controller_if;
    import cpu_pkg::*;

    logic [WIDTH-1:0] opcode;
    logic             zero;
    logic             sel;
    logic             rd;
    logic             ld_ir;
    logic             inc_pc;
    logic             ld_pc;
    logic             halt;
    logic             data_e;
    logic             ld_ac;
    logic             wr;
    logic [WIDTH-1:0] phase;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase
    );

endinterface

// File: rtl/phase_counter.sv
// 3-bit wrapping instruction-phase counter; synchronous reset, held while disabled.
module phase_counter
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            count <= INST_ADDR;
        else if (enable)
            count <= count + 3'd1;
    end

endmodule

// File: rtl/cpu_controller.sv
// veriRISC instruction sequencer: steps 8 phases per instruction and decodes
// phase/opcode/zero into datapath strobes, with a sticky halt on HLT.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    cpu_controller_if.master  bus
);

    logic [WIDTH-1:0] phase;
    logic             halt_req;
    logic             halt_reg;
    logic             halt;
    logic             aluop;

    logic sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr;

    assign aluop    = is_aluop(bus.opcode);
    assign halt_req = (phase == OP_ADDR) && (bus.opcode == HLT);
    // Request term makes halt visible in the same cycle the HLT is decoded.
    assign halt     = halt_req | halt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            halt_reg <= 1'b0;
        else if (halt_req)
            halt_reg <= 1'b1;
    end

    phase_counter u_phase_counter (
        .clk    (clk),
        .rst    (rst),
        .enable (!halt),
        .count  (phase)
    );

    // NOTE: every strobe gets a default before the case so no latch is inferred.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        case (phase)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = (bus.opcode != HLT);
            end
            OP_FETCH: begin
                rd = aluop;
            end
            ALU_OP: begin
                rd     = aluop;
                inc_pc = (bus.opcode == SKZ) && bus.zero;
                ld_pc  = (bus.opcode == JMP);
                data_e = (bus.opcode == STO);
            end
            STORE: begin
                // JMP raises both PC strobes; the counter's load priority makes the target win.
                rd     = aluop;
                ld_ac  = aluop;
                inc_pc = (bus.opcode == JMP);
                ld_pc  = (bus.opcode == JMP);
                data_e = (bus.opcode == STO);
                wr     = (bus.opcode == STO);
            end
            default: ;
        endcase
        if (halt) begin
            sel    = 1'b0;
            rd     = 1'b0;
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            data_e = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
        end
    end

    assign bus.sel    = sel;
    assign bus.rd     = rd;
    assign bus.ld_ir  = ld_ir;
    assign bus.inc_pc = inc_pc;
    assign bus.ld_pc  = ld_pc;
    assign bus.halt   = halt;
    assign bus.data_e = data_e;
    assign bus.ld_ac  = ld_ac;
    assign bus.wr     = wr;
    assign bus.phase  = phase;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-phase strobe vectors for each opcode class,
// halt freeze, mid-instruction reset, and a small PC model fed by ld_pc/inc_pc.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total_count = 0;
    int   pass_count  = 0;
    logic [4:0] pc;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Program counter as the datapath sees it: load has priority over enable.
    always @(posedge clk) begin
        if (rst)
            pc <= 5'd0;
        else if (bus.ld_pc)
            pc <= 5'd17;
        else if (bus.inc_pc)
            pc <= pc + 5'd1;
    end

    // Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}
    function automatic logic [8:0] strobes();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                bus.halt, bus.data_e, bus.ld_ac, bus.wr};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected)
            pass_count++;
        else
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [8:0] S_IA   = 9'b100000000;
    localparam logic [8:0] S_IF   = 9'b110000000;
    localparam logic [8:0] S_IL   = 9'b111000000;
    localparam logic [8:0] S_INC  = 9'b000100000;
    localparam logic [8:0] S_RD   = 9'b010000000;
    localparam logic [8:0] S_NONE = 9'b000000000;
    localparam logic [8:0] S_HALT = 9'b000001000;

    // Runs one full instruction from phase 0, checking phase and strobes in every phase.
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input logic [0:7][8:0] expv);
        bus.opcode = op;
        bus.zero   = z;
        for (int p = 0; p < 8; p++) begin
            check($sformatf("%s phase@%0d", name, p), {29'd0, bus.phase}, p);
            check($sformatf("%s strobes@%0d", name, p), {23'd0, strobes()}, {23'd0, expv[p]});
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.opcode = ADD;
        bus.zero   = 1'b0;
        tick();
        check("reset phase", {29'd0, bus.phase}, 0);
        check("reset strobes", {23'd0, strobes()}, {23'd0, S_IA});
        check("reset pc", {27'd0, pc}, 0);
        rst = 1'b0;

        run_instr("ADD", ADD, 1'b0,
                  {S_IA, S_IF, S_IL, S_IL, S_INC, S_RD, S_RD, 9'b010000010});
        check("ADD wrap phase", {29'd0, bus.phase}, 0);
        check("ADD pc", {27'd0, pc}, 1);

        run_instr("STO", STO, 1'b0,
                  {S_IA, S_IF, S_IL, S_IL, S_INC, S_NONE, 9'b000000100, 9'b000000101});

        run_instr("SKZ1", SKZ, 1'b1,
                  {S_IA, S_IF, S_IL, S_IL, S_INC, S_NONE, S_INC, S_NONE});
        check("SKZ taken pc", {27'd0, pc}, 4);

        run_instr("SKZ0", SKZ, 1'b0,
                  {S_IA, S_IF, S_IL, S_IL, S_INC, S_NONE, S_NONE, S_NONE});
        check("SKZ not taken pc", {27'd0, pc}, 5);

        run_instr("JMP", JMP, 1'b0,
                  {S_IA, S_IF, S_IL, S_IL, S_INC, S_NONE, 9'b000010000, 9'b000110000});
        check("JMP pc", {27'd0, pc}, 17);

        run_instr("AND", AND, 1'b1,
                  {S_IA, S_IF, S_IL, S_IL, S_INC, S_RD, S_RD, 9'b010000010});

        // HLT: walk into OP_ADDR, then the phase must freeze with only halt raised.
        bus.opcode = HLT;
        bus.zero   = 1'b0;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("HLT phase@%0d", p), {29'd0, bus.phase}, p);
            tick();
        end
        check("HLT request strobes", {23'd0, strobes()}, {23'd0, S_HALT});
        for (int i = 0; i < 22; i++) begin
            tick();
            check($sformatf("HLT hold phase %0d", i), {29'd0, bus.phase}, 4);
            check($sformatf("HLT hold strobes %0d", i), {23'd0, strobes()}, {23'd0, S_HALT});
        end
        bus.opcode = ADD;
        #1;
        check("HLT opcode change strobes", {23'd0, strobes()}, {23'd0, S_HALT});
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("HLT after ADD phase %0d", i), {29'd0, bus.phase}, 4);
            check($sformatf("HLT after ADD strobes %0d", i), {23'd0, strobes()}, {23'd0, S_HALT});
        end
        check("HLT pc frozen", {27'd0, pc}, 18);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post-halt reset phase", {29'd0, bus.phase}, 0);
        check("post-halt reset strobes", {23'd0, strobes()}, {23'd0, S_IA});

        // LDA aborted by reset at OP_FETCH: ld_ac must never fire for it.
        bus.opcode = LDA;
        for (int p = 0; p < 5; p++) begin
            check($sformatf("LDA phase@%0d", p), {29'd0, bus.phase}, p);
            check($sformatf("LDA ld_ac@%0d", p), {31'd0, bus.ld_ac}, 0);
            tick();
        end
        check("LDA at OP_FETCH phase", {29'd0, bus.phase}, 5);
        check("LDA at OP_FETCH strobes", {23'd0, strobes()}, {23'd0, S_RD});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("LDA abort phase", {29'd0, bus.phase}, 0);
        check("LDA abort ld_ac", {31'd0, bus.ld_ac}, 0);
        check("LDA abort strobes", {23'd0, strobes()}, {23'd0, S_IA});

        run_instr("LDA", LDA, 1'b0,
                  {S_IA, S_IF, S_IL, S_IL, S_INC, S_RD, S_RD, 9'b010000010});

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
